mips_mem_arbiter: RTL

- Shares one single-ported unified memory between the MIPS instruction-fetch port (IF) and the data-memory port (DM).
- Arbitrates between the two, sequences each access through a fixed-latency memory, and returns the read data or write acknowledge to the port that owns the access.
- Drives a pipeline stall while any access is pending.
- Sits between the MIPS core's fetch/memory stages and the shared memory model.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mips_mem_arb_pick.sv | 33 +++
 rtl/mips_mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and default widths for the MIPS memory arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mips_mem_arb_pick.sv
// mips_mem_arb_pick: combinational winner select between fetch and data ports.
// MIPS_MEM_ARB_RR_EN defined: ties go to the port that did not own the last access.
// MIPS_MEM_ARB_RR_EN undefined: ties always go to DM.
module mips_mem_arb_pick
    import mips_mem_pkg::*;
(
`ifdef MIPS_MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    input  logic   if_req,
    input  logic   dm_req,
    output logic   any_req,
    output owner_t winner
);

    // winner is only meaningful while any_req is high
    always_comb begin
        any_req = if_req | dm_req;
        winner  = OWN_IF;
`ifdef MIPS_MEM_ARB_RR_EN
        if (if_req && dm_req) begin
            winner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (dm_req) begin
            winner = OWN_DM;
        end
`else
        if (dm_req) begin
            winner = OWN_DM;
        end
`endif
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-ported fixed-latency memory between the
// MIPS fetch (IF) and data (DM) ports, stalling the pipeline while busy.
// Optional macro MIPS_MEM_ARB_RR_EN selects round-robin arbitration on ties.
//
// state  | meaning
// IDLE   | nothing in flight, sampling requests
// ACCESS | memory strobe issued, grant pulsed to the winner
// WAIT   | memory latency countdown, address/we/wdata held
// RESP   | valid pulsed to the owner, next request sampled
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t           state, state_nxt;
    owner_t           owner;
    owner_t           winner;
    logic             any_req;
    logic             start;
    logic             done;
    logic [CNT_W-1:0] cnt;

    // owner doubles as the last-owner history for round-robin
    mips_mem_arb_pick u_pick (
`ifdef MIPS_MEM_ARB_RR_EN
        .last_owner (owner),
`endif
        .if_req     (if_req),
        .dm_req     (dm_req),
        .any_req    (any_req),
        .winner     (winner)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state; start launches a new access, done ends the latency wait
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (any_req) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // registered outputs, latched access and latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_IF;
            cnt       <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_gnt   <= start && (winner == OWN_IF);
            dm_gnt   <= start && (winner == OWN_DM);
            mem_en   <= start;
            if_valid <= done && (owner == OWN_IF);
            dm_valid <= done && (owner == OWN_DM);

            if (start) begin
                owner <= winner;
                if (winner == OWN_DM) begin
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                    mem_we    <= dm_we;
                end else begin
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_we    <= 1'b0;
                end
            end else if (done) begin
                mem_we <= 1'b0;
            end

            if (state == ACCESS) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            // write acks leave the read-data registers untouched
            if (done && !mem_we) begin
                if (owner == OWN_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    dm_rdata <= mem_rdata;
                end
            end
        end
    end

    // stall is forced low while reset is held
    assign stall = reset & ((if_req & ~if_gnt) | (dm_req & ~dm_gnt) |
                            ((state != IDLE) && (state != RESP)));

endmodule
